// File: rtl/fixed_bcd_conv.sv
// Converts a Q8.8 value to sign + four BCD digits (hundreds, tens, ones, tenths).
// The integer part uses an 8-step sequential double-dabble; the tenths digit is computed at capture.
module fixed_bcd_conv #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        neg,
    output logic [3:0]  digit3,
    output logic [3:0]  digit2,
    output logic [3:0]  digit1,
    output logic [3:0]  digit0
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic   [3:0]  cnt;
    logic          capture;
    logic          last;
    logic          is_neg;
    logic signed [15:0] mag_s;
    logic   [15:0] mag;
    logic   [19:0] sr_p0;
    logic   [19:0] sr_nxt;
    logic   [3:0]  tenths_p0;
    logic          neg_p0;

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
    function automatic logic [19:0] dabble_step(input logic [19:0] sr);
        logic [19:0] adj;
        adj = sr;
        for (int i = 0; i < 3; i++) begin
            if (adj[8 + 4*i +: 4] >= 4'd5)
                adj[8 + 4*i +: 4] = adj[8 + 4*i +: 4] + 4'd3;
        end
        return {adj[18:0], 1'b0};
    endfunction

    // floor(frac * 10 / 256), truncating.
    function automatic logic [3:0] tenths_of(input logic [7:0] frac);
        logic [11:0] prod;
        prod = {4'b0000, frac} * 12'd10;
        return prod[11:8];
    endfunction

    // Low 16 bits of the 17-bit negation equal the 16-bit negation, so -128.0 maps to 0x8000.
    assign is_neg  = (SIGNED == 1'b1) && value[15];
    assign mag_s   = is_neg ? -$signed(value) : $signed(value);
    assign mag     = mag_s;

    assign capture = start && (state != CONV);
    assign last    = (state == CONV) && (cnt == 4'd7);
    assign sr_nxt  = dabble_step(sr_p0);
    assign busy    = (state == CONV);
    assign done    = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (capture)
                cnt <= 4'd0;
            else if (state == CONV)
                cnt <= cnt + 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (cnt == 4'd7) state_nxt = DONE;
            DONE:    state_nxt = start ? CONV : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: captured operand and shift register
    always_ff @(posedge clk) begin
        if (capture) begin
            sr_p0     <= {12'd0, mag[15:8]};
            tenths_p0 <= tenths_of(mag[7:0]);
            neg_p0    <= is_neg;
        end else if (state == CONV) begin
            sr_p0 <= sr_nxt;
        end
    end

    // Output stage: digits update only when a conversion completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg    <= 1'b0;
            digit3 <= 4'd0;
            digit2 <= 4'd0;
            digit1 <= 4'd0;
            digit0 <= 4'd0;
        end else if (last) begin
            neg    <= neg_p0;
            digit3 <= sr_nxt[19:16];
            digit2 <= sr_nxt[15:12];
            digit1 <= sr_nxt[11:8];
            digit0 <= tenths_p0;
        end
    end

endmodule

// File: tb/tb_fixed_bcd_conv.sv
// Directed bench for fixed_bcd_conv: a signed and an unsigned instance share clock, reset and inputs.
module tb_fixed_bcd_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        start = 1'b0;

    logic       s_busy, s_done, s_neg;
    logic [3:0] s_d3, s_d2, s_d1, s_d0;
    logic       u_busy, u_done, u_neg;
    logic [3:0] u_d3, u_d2, u_d1, u_d0;

    int checks = 0;
    int failures = 0;
    int pulses;

    fixed_bcd_conv #(.SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .value(value), .start(start),
        .busy(s_busy), .done(s_done), .neg(s_neg),
        .digit3(s_d3), .digit2(s_d2), .digit1(s_d1), .digit0(s_d0)
    );

    fixed_bcd_conv #(.SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .value(value), .start(start),
        .busy(u_busy), .done(u_done), .neg(u_neg),
        .digit3(u_d3), .digit2(u_d2), .digit1(u_d1), .digit0(u_d0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs already driven before a rising edge; that edge samples start.
    task automatic conv_body(input string tag, input logic [15:0] s_dig, input logic s_ng,
                             input logic [15:0] u_dig, input logic u_ng);
        @(posedge clk); #1;
        check({tag, " busy_after_start"}, {14'd0, s_busy, u_busy}, 16'h0003);
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if (s_done || u_done) pulses++;
        end
        check({tag, " no_early_done"}, 16'(pulses), 16'd0);
        @(posedge clk); #1;
        check({tag, " done"}, {14'd0, s_done, u_done}, 16'h0003);
        check({tag, " busy_clear"}, {14'd0, s_busy, u_busy}, 16'h0000);
        check({tag, " s_digits"}, {s_d3, s_d2, s_d1, s_d0}, s_dig);
        check({tag, " s_neg"}, {15'd0, s_neg}, {15'd0, s_ng});
        check({tag, " u_digits"}, {u_d3, u_d2, u_d1, u_d0}, u_dig);
        check({tag, " u_neg"}, {15'd0, u_neg}, {15'd0, u_ng});
    endtask

    task automatic do_conv(input string tag, input logic [15:0] v, input logic [15:0] s_dig,
                           input logic s_ng, input logic [15:0] u_dig, input logic u_ng);
        @(negedge clk);
        value = v;
        start = 1'b1;
        conv_body(tag, s_dig, s_ng, u_dig, u_ng);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", {12'd0, s_busy, s_done, u_busy, u_done}, 16'h0000);
        check("reset_digits", {s_d3, s_d2, s_d1, s_d0}, 16'h0000);
        check("reset_neg", {14'd0, s_neg, u_neg}, 16'h0000);

        // First start accepted on the first edge after release
        @(negedge clk);
        rst = 1'b1;
        value = 16'h0180;
        start = 1'b1;
        conv_body("v0180", 16'h0015, 1'b0, 16'h0015, 1'b0);

        @(posedge clk); #1;
        check("done_one_cycle", {14'd0, s_done, u_done}, 16'h0000);
        check("digits_hold", {s_d3, s_d2, s_d1, s_d0}, 16'h0015);

        do_conv("v7fff", 16'h7FFF, 16'h1279, 1'b0, 16'h1279, 1'b0);
        do_conv("v8000", 16'h8000, 16'h1280, 1'b1, 16'h1280, 1'b0);
        do_conv("vffff", 16'hFFFF, 16'h0000, 1'b1, 16'h2559, 1'b0);
        do_conv("vff00", 16'hFF00, 16'h0010, 1'b1, 16'h2550, 1'b0);
        do_conv("v0000", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        do_conv("vff80", 16'hFF80, 16'h0005, 1'b1, 16'h2555, 1'b0);

        // Value change and start pulse during CONV are ignored
        @(negedge clk);
        value = 16'h0180;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 2) begin
                value = 16'h7FFF;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (s_done) pulses++;
        end
        @(posedge clk); #1;
        check("ignore_done", {15'd0, s_done}, 16'h0001);
        check("ignore_pulses", 16'(pulses), 16'd0);
        check("ignore_digits", {s_d3, s_d2, s_d1, s_d0}, 16'h0015);

        // Start held in the DONE cycle chains straight into a new conversion
        @(negedge clk);
        value = 16'h0100;
        start = 1'b1;
        conv_body("chain", 16'h0010, 1'b0, 16'h0010, 1'b0);

        // Reset during the 4th CONV cycle aborts the conversion
        @(negedge clk);
        value = 16'h7FFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ctrl", {14'd0, s_busy, s_done}, 16'h0000);
        check("abort_digits", {s_d3, s_d2, s_d1, s_d0}, 16'h0000);
        check("abort_neg", {15'd0, s_neg}, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (s_done || u_done || s_busy) pulses++;
        end
        check("abort_quiet", 16'(pulses), 16'd0);
        do_conv("after_abort", 16'h7FFF, 16'h1279, 1'b0, 16'h1279, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fixed_bcd_conv.md
FIXED_BCD_CONV -- requirements
Module: fixed_bcd_conv

Interface
REQ-001 Parameter: SIGNED, default 1, input interpreted as two's-complement Q8.8 when 1 and as unsigned Q8.8 when 0.
REQ-002 clk  input  1  single clock, all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 value  input  16  Q8.8 number from the arithmetic stage (result_fiA / result_fiM); bits [15:8] integer, [7:0] fraction.
REQ-005 start  input  1  conversion request, sampled on a rising edge while not busy.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  single-cycle pulse when new digits are valid.
REQ-008 neg  output  1  sign of the last converted value (1 = negative).
REQ-009 digit3 / digit2 / digit1 / digit0  output  4 each  BCD hundreds, tens, ones, tenths; directly drives ssdController4 digit inputs.

Function
REQ-010 The FSM SHALL have three states: IDLE, CONV, DONE.
REQ-011 In IDLE or DONE, start=1 at an edge SHALL capture value, enter CONV, clear the 4-bit iteration counter and load the shift register; busy goes to 1 on that edge.
REQ-012 Magnitude: with SIGNED=1 and value[15]=1, the magnitude SHALL be the 17-bit negation of value and neg=1; otherwise the magnitude is value and neg=0.
REQ-013 Integer magnitude (0..255) SHALL be converted by 8 sequential double-dabble iterations, one per clock in CONV (add 3 to any BCD nibble >=5, then shift left by 1).
REQ-014 Tenths digit SHALL be floor(frac*10/256), frac being the 8 magnitude fraction bits (truncation, no rounding); computed once at capture.
REQ-015 After the 8th iteration edge the FSM SHALL enter DONE, register all four digits and neg, set done=1 and busy=0 on that same edge.
REQ-016 Latency: done SHALL go high exactly 8 rising edges after the edge that sampled start.
REQ-017 done SHALL be high for exactly one cycle; DONE returns to IDLE on the next edge unless start=1, in which case it enters CONV directly.
REQ-018 start SHALL be ignored while in CONV; value changes during CONV SHALL not affect the result.
REQ-019 digit3..digit0 and neg SHALL hold their last registered values until the next DONE and SHALL not show intermediate shift-register contents.
REQ-020 Integer magnitude 128 (signed -128.x) and up to 255 (unsigned) SHALL fit without overflow; no overflow output exists.
REQ-021 Negative zero does not exist: value 0x0000 gives neg=0; 0xFF80 (-0.5) gives neg=1, digits 0,0,0,5.

Reset
REQ-022 rst=0 SHALL immediately force IDLE, counter 0, busy=0, done=0, neg=0, all digits 0, regardless of clock.
REQ-023 Reset asserted mid-conversion SHALL abort it; after release no done pulse occurs until a new start.
REQ-024 The first start SHALL be accepted on the first rising edge with rst=1.

Verification
REQ-025 value=0x0180, start pulse -> after 8 edges done=1, neg=0, digits 0,0,1,5, busy=0.
REQ-026 value=0x7FFF -> digits 1,2,7,9, neg=0; value=0x8000 (SIGNED=1) -> digits 1,2,8,0, neg=1; with SIGNED=0 -> 0x8000 gives 1,2,8,0, neg=0, 0xFFFF gives 2,5,5,9.
REQ-027 value=0xFF00 -> neg=1, digits 0,0,1,0; value=0x0000 -> neg=0, digits 0,0,0,0.
REQ-028 Start at 0x0180, change value to 0x7FFF and pulse start during CONV -> single done, digits 0,0,1,5; start held high in DONE cycle -> second conversion begins, busy=1 next cycle.
REQ-029 Assert rst at 4th CONV cycle -> outputs zero immediately; release, wait 20 cycles -> no done; then new start converts correctly.
